// File: rtl/ex_mult_unit_if.sv
// Handshake and operand/result bundle between the EX-stage control and the
// multi-cycle multiplier.
interface ex_mult_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            signed_op;
  logic            kill;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, signed_op, kill, opA, opB,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, kill, opA, opB,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/ex_mult_unit.sv
// Multi-cycle shift-add XLEN x XLEN multiplier for the EX stage, STEP bits per cycle.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier is zero.
module ex_mult_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  ex_mult_unit_if.slave mif
);

  localparam int N     = XLEN / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * XLEN;

  if ((STEP != 1 && STEP != 2 && STEP != 4) || (XLEN % STEP) != 0) begin : g_bad_step
    $error("ex_mult_unit: STEP must be 1, 2 or 4 and divide XLEN");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     partial;
  logic [PW-1:0]     acc_sum;
  logic [PW-1:0]     result;
  logic [PW-1:0]     hilo;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   mplier_nxt;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [CNT_W-1:0]  cnt;
  logic              sign;
  logic              busy_q;
  logic              accept;
  logic              last;

  assign accept = (state == IDLE) && mif.start && !mif.kill;

  // Operand magnitudes; -0x80000000 wraps back to 0x80000000, the correct unsigned magnitude.
  assign mag_a = (mif.signed_op && mif.opA[XLEN-1]) ? -mif.opA : mif.opA;
  assign mag_b = (mif.signed_op && mif.opB[XLEN-1]) ? -mif.opB : mif.opB;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  assign acc_sum    = acc + partial;
  assign result     = sign ? -acc_sum : acc_sum;
  assign mplier_nxt = mplier >> STEP;

`ifdef MULT_EARLY_EXIT_EN
  assign last = (cnt == CNT_W'(N - 1)) || (mplier_nxt == '0);
`else
  assign last = (cnt == CNT_W'(N - 1));
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (mif.kill) state_nxt = IDLE;
  end

  // stall is forced low while reset is held, even if start is still asserted.
  always_comb begin
    mif.stall = 1'b0;
    mif.done  = 1'b0;
    if (rst) begin
      mif.stall = (state == RUN) || ((state == IDLE) && mif.start && !mif.kill);
      mif.done  = (state == DONE);
    end
  end

  // NOTE: the datapath registers are reset too, so a reset mid-operation leaves no stale product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      hilo   <= '0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      if (accept) begin
        mcand  <= {{XLEN{1'b0}}, mag_a};
        mplier <= mag_b;
        acc    <= '0;
        cnt    <= '0;
        sign   <= mif.signed_op & (mif.opA[XLEN-1] ^ mif.opB[XLEN-1]);
      end else if (state == RUN) begin
        acc    <= acc_sum;
        mplier <= mplier_nxt;
        mcand  <= mcand << STEP;
        cnt    <= cnt + 1'b1;
        if (last && !mif.kill) hilo <= result;
      end
    end
  end

  assign mif.busy = busy_q;
  assign mif.hi   = hilo[PW-1:XLEN];
  assign mif.lo   = hilo[XLEN-1:0];

endmodule

// File: tb/tb_ex_mult_unit.sv
// Directed-vector bench for ex_mult_unit: product table plus reset, kill and
// back-to-back sequences. Latency expectations follow MULT_EARLY_EXIT_EN.
module tb_ex_mult_unit;

  localparam int XLEN = 32;
  localparam int STEP = 1;
  localparam int N    = XLEN / STEP;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ex_mult_unit_if #(.XLEN(XLEN)) mif ();

  ex_mult_unit #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Expected number of RUN cycles for a given multiplier.
  function automatic int exp_run(input logic s, input logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int h;
    int rc;
    m = (s && b[31]) ? -b : b;
    h = -1;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    rc = (h + STEP) / STEP;
    return (rc < 1) ? 1 : rc;
`else
    return N;
`endif
  endfunction

  // Called at posedge+1; returns in the done cycle (or after the bound expires).
  task automatic run_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int done_at, output logic [63:0] prod);
    mif.signed_op = s;
    mif.opA       = a;
    mif.opB       = b;
    mif.kill      = 1'b0;
    mif.start     = 1'b1;
    stalls  = 0;
    done_at = -1;
    prod    = '0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (mif.stall) stalls++;
      if (mif.done) begin
        done_at = c;
        prod    = {mif.hi, mif.lo};
        break;
      end
      @(posedge clk);
      #1;
    end
    mif.start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stalls;
    int          done_at;
    int          dones;
    int          extra;
    logic [63:0] prod;
    logic [63:0] p1;
    logic [63:0] p2;
    logic        switched;
    logic        gap_stall;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[1] = '{1'b1, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA};
    vecs[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3] = '{1'b0, 32'h12345678, 32'h00000003, 64'h00000000_369D0368};
    vecs[4] = '{1'b0, 32'h12345678, 32'h00000000, 64'h00000000_00000000};
    vecs[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000};
    vecs[6] = '{1'b1, 32'h00000007, 32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFCF};
    vecs[7] = '{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
    vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[9] = '{1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000_FFFE0001};

    // Reset state, with start driven high to show stall stays low in reset.
    mif.start     = 1'b1;
    mif.signed_op = 1'b0;
    mif.kill      = 1'b0;
    mif.opA       = 32'd3;
    mif.opB       = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 64'(mif.stall), 64'd0);
    check("reset_busy",  64'(mif.busy),  64'd0);
    check("reset_done",  64'(mif.done),  64'd0);
    check("reset_hilo",  {mif.hi, mif.lo}, 64'd0);
    mif.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Product table with latency and pulse checks.
    for (int i = 0; i < 10; i++) begin
      run_mult(vecs[i].s, vecs[i].a, vecs[i].b, stalls, done_at, prod);
      check($sformatf("vec%0d_product", i), prod, vecs[i].p);
      check($sformatf("vec%0d_done_cycle", i), 64'(done_at), 64'(exp_run(vecs[i].s, vecs[i].b) + 1));
      check($sformatf("vec%0d_stall_cycles", i), 64'(stalls), 64'(exp_run(vecs[i].s, vecs[i].b) + 1));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), 64'(mif.done), 64'd0);
      check($sformatf("vec%0d_hilo_held", i), {mif.hi, mif.lo}, vecs[i].p);
    end

    // Kill in RUN cycle 10: prime hi:lo = 1:2 first.
    run_mult(1'b0, 32'h80000001, 32'h00000002, stalls, done_at, prod);
    check("kill_prime", prod, 64'h00000001_00000002);
    @(posedge clk);
    #1;
    mif.signed_op = 1'b0;
    mif.opA       = 32'd5;
    mif.opB       = 32'hFFFFFFFF;
    mif.start     = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    check("kill_busy_before", 64'(mif.busy), 64'd1);
    mif.kill = 1'b1;
    @(posedge clk);
    #1;
    mif.kill  = 1'b0;
    mif.start = 1'b0;
    #1;
    check("kill_stall_after", 64'(mif.stall), 64'd0);
    check("kill_busy_after",  64'(mif.busy),  64'd0);
    check("kill_done_after",  64'(mif.done),  64'd0);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (mif.done) extra++;
    end
    check("kill_no_done", 64'(extra), 64'd0);
    check("kill_hilo_kept", {mif.hi, mif.lo}, 64'h00000001_00000002);

    // Back-to-back: start held through both operations.
    dones     = 0;
    p1        = '0;
    p2        = '0;
    switched  = 1'b0;
    gap_stall = 1'b0;
    mif.signed_op = 1'b0;
    mif.opA       = 32'd7;
    mif.opB       = 32'd6;
    mif.start     = 1'b1;
    for (int c = 0; c < 300 && dones < 2; c++) begin
      #1;
      if (mif.done) begin
        dones++;
        if (dones == 1) p1 = {mif.hi, mif.lo};
        else            p2 = {mif.hi, mif.lo};
      end
      @(posedge clk);
      #1;
      if (dones == 1 && !switched) begin
        switched      = 1'b1;
        mif.signed_op = 1'b1;
        mif.opA       = 32'hFFFFFFFF;
        mif.opB       = 32'd5;
        #1;
        gap_stall = mif.stall;
      end
    end
    mif.start = 1'b0;
    check("b2b_first",  p1, 64'd42);
    check("b2b_second", p2, 64'hFFFFFFFF_FFFFFFFB);
    check("b2b_restart_stall", 64'(gap_stall), 64'd1);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (mif.done) extra++;
      @(posedge clk);
      #1;
    end
    check("b2b_done_count", 64'(dones + extra), 64'd2);

    // Asynchronous reset between edges mid-RUN.
    mif.signed_op = 1'b0;
    mif.opA       = 32'hFFFFFFFF;
    mif.opB       = 32'hFFFFFFFF;
    mif.start     = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("areset_busy_before", 64'(mif.busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("areset_stall", 64'(mif.stall), 64'd0);
    check("areset_busy",  64'(mif.busy),  64'd0);
    check("areset_done",  64'(mif.done),  64'd0);
    check("areset_hilo",  {mif.hi, mif.lo}, 64'd0);
    mif.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_mult(1'b1, 32'hFFFFFFFE, 32'h00000003, stalls, done_at, prod);
    check("post_reset_product", prod, 64'hFFFFFFFF_FFFFFFFA);
    check("post_reset_done_cycle", 64'(done_at), 64'(exp_run(1'b1, 32'h00000003) + 1));
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
